// File: rtl/wb_regfile_pkg.sv
// Shared pipeline package: default datapath widths and the hard-wired zero register.
package wb_regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;

    // Architectural register that always reads zero and ignores writes.
    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/wb_regfile_if.sv
// Writeback/decode bus between the MEM/WB stage, the decode stage and the register file.
interface wb_regfile_if #(
    parameter int unsigned DATA_W = wb_regfile_pkg::DEF_DATA_W,
    parameter int unsigned ADDR_W = wb_regfile_pkg::DEF_ADDR_W
);

    logic              RFWEW;
    logic              MtoRFSelW;
    logic [DATA_W-1:0] DMOutW;
    logic [DATA_W-1:0] ALUOutW;
    logic [ADDR_W-1:0] rtdW;
    logic [ADDR_W-1:0] rsD;
    logic [ADDR_W-1:0] rtD;
    logic [DATA_W-1:0] RD1D;
    logic [DATA_W-1:0] RD2D;
    logic [DATA_W-1:0] ResultW;

    // Pipeline side: drives writeback and read addresses, consumes read data.
    modport master (
        output RFWEW, MtoRFSelW, DMOutW, ALUOutW, rtdW, rsD, rtD,
        input  RD1D, RD2D, ResultW
    );

    // Register-file side.
    modport slave (
        input  RFWEW, MtoRFSelW, DMOutW, ALUOutW, rtdW, rsD, rtD,
        output RD1D, RD2D, ResultW
    );

endinterface

// File: rtl/wb_regfile_rf_core.sv
// rf_core: 2-read/1-write register array with asynchronous clear and a read-only zero register.
module rf_core
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [NumRegs];

    // Storage: reset clears everything at once; address zero is never written.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRegs; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != ADDR_W'(REG_ZERO))) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational read ports; address zero is forced to zero.
    always_comb begin
        rdata1_o = (raddr1_i == ADDR_W'(REG_ZERO)) ? '0 : mem_q[raddr1_i];
        rdata2_o = (raddr2_i == ADDR_W'(REG_ZERO)) ? '0 : mem_q[raddr2_i];
    end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback result mux plus register file.
// Optional macro WB_RF_BYPASS_EN forwards the writeback result to a matching read port in the
// same cycle; without it the reads return stored values only.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic         CLK,
    input  logic         RST,
    wb_regfile_if.slave  bus
);

    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] core_rd1;
    logic [DATA_W-1:0] core_rd2;

    // Writeback result select: memory data or ALU result.
    always_comb begin
        result = bus.MtoRFSelW ? bus.DMOutW : bus.ALUOutW;
    end

    rf_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rf_core (
        .clk_i    (CLK),
        .rst_i    (RST),
        .we_i     (bus.RFWEW),
        .waddr_i  (bus.rtdW),
        .wdata_i  (result),
        .raddr1_i (bus.rsD),
        .raddr2_i (bus.rtD),
        .rdata1_o (core_rd1),
        .rdata2_o (core_rd2)
    );

`ifdef WB_RF_BYPASS_EN
    logic fwd_valid;

    // Write-through forwarding; suppressed in reset so reads stay zero.
    always_comb begin
        fwd_valid = !RST && bus.RFWEW && (bus.rtdW != ADDR_W'(REG_ZERO));
        bus.RD1D  = (fwd_valid && (bus.rtdW == bus.rsD)) ? result : core_rd1;
        bus.RD2D  = (fwd_valid && (bus.rtdW == bus.rtD)) ? result : core_rd2;
    end
`else
    // Stored values only; hazards are resolved by the hazard unit.
    always_comb begin
        bus.RD1D = core_rd1;
        bus.RD2D = core_rd2;
    end
`endif

    // Expose the selected writeback value.
    always_comb begin
        bus.ResultW = result;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (default or WB_RF_BYPASS_EN build).
module tb_wb_regfile;

`ifdef WB_RF_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one write, take one edge, then drop the enable.
    task automatic wr(input logic [4:0] addr, input logic sel,
                      input logic [31:0] alu, input logic [31:0] dm);
        bus.RFWEW     = 1'b1;
        bus.rtdW      = addr;
        bus.MtoRFSelW = sel;
        bus.ALUOutW   = alu;
        bus.DMOutW    = dm;
        @(posedge CLK);
        #1;
        bus.RFWEW     = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        bus.rsD = a1;
        bus.rtD = a2;
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        RST           = 1'b0;
        bus.RFWEW     = 1'b0;
        bus.MtoRFSelW = 1'b0;
        bus.DMOutW    = '0;
        bus.ALUOutW   = '0;
        bus.rtdW      = '0;
        bus.rsD       = '0;
        bus.rtD       = '0;
        #2;
        RST = 1'b1;
        rd(5'd1, 5'd2);
        check("reset_rd1", bus.RD1D, 32'h0);
        check("reset_rd2", bus.RD2D, 32'h0);

        // Write attempted while in reset must be ignored.
        wr(5'd2, 1'b0, 32'h0000_0BAD, 32'h0);
        rd(5'd1, 5'd2);
        check("reset_write_ignored", bus.RD2D, 32'h0);
        RST = 1'b0;
        #1;
        check("after_reset_r2", bus.RD2D, 32'h0);

        // Result mux is combinational.
        bus.MtoRFSelW = 1'b0; bus.ALUOutW = 32'h0000_00AA; bus.DMOutW = 32'h0000_00BB;
        #1;
        check("result_alu", bus.ResultW, 32'h0000_00AA);
        bus.MtoRFSelW = 1'b1;
        #1;
        check("result_mem", bus.ResultW, 32'h0000_00BB);

        // Write-select through ALU then memory path.
        wr(5'd5, 1'b0, 32'h0000_1234, 32'h1111_1111);
        rd(5'd5, 5'd0);
        check("wsel_alu", bus.RD1D, 32'h0000_1234);
        wr(5'd5, 1'b1, 32'h2222_2222, 32'hDEAD_BEEF);
        rd(5'd5, 5'd5);
        check("wsel_mem_rd1", bus.RD1D, 32'hDEAD_BEEF);
        check("wsel_mem_rd2", bus.RD2D, 32'hDEAD_BEEF);

        // Register zero stays zero.
        wr(5'd0, 1'b0, 32'hFFFF_FFFF, 32'h0);
        rd(5'd0, 5'd0);
        check("zero_rd1", bus.RD1D, 32'h0);
        check("zero_rd2", bus.RD2D, 32'h0);

        // Disabled write leaves storage, including with X data.
        wr(5'd7, 1'b0, 32'h0000_0011, 32'h0);
        bus.RFWEW = 1'b0; bus.rtdW = 5'd7; bus.MtoRFSelW = 1'b0; bus.ALUOutW = 32'h55;
        rd(5'd5, 5'd7);
        @(posedge CLK);
        #1;
        check("disabled_r7", bus.RD2D, 32'h0000_0011);
        bus.MtoRFSelW = 1'bx; bus.ALUOutW = 'x; bus.DMOutW = 'x; bus.rtdW = 'x;
        @(posedge CLK);
        #1;
        check("disabled_x_r7", bus.RD2D, 32'h0000_0011);
        check("disabled_x_r5", bus.RD1D, 32'hDEAD_BEEF);

        // Same-cycle read-during-write to r9.
        wr(5'd9, 1'b0, 32'h0000_0099, 32'h0);
        bus.RFWEW = 1'b1; bus.rtdW = 5'd9; bus.MtoRFSelW = 1'b0;
        bus.ALUOutW = 32'hA5A5_A5A5; bus.DMOutW = 32'h0;
        rd(5'd9, 5'd9);
        check("bypass_rd1", bus.RD1D, Bypass ? 32'hA5A5_A5A5 : 32'h0000_0099);
        check("bypass_rd2", bus.RD2D, Bypass ? 32'hA5A5_A5A5 : 32'h0000_0099);
        @(posedge CLK);
        #1;
        bus.RFWEW = 1'b0;
        #1;
        check("after_edge_r9", bus.RD1D, 32'hA5A5_A5A5);

        // Fill r1..r31 with their index.
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 1'b0, 32'(i), 32'h0);
        end
        rd(5'd3, 5'd31);
        check("fill_r3", bus.RD1D, 32'd3);
        check("fill_r31", bus.RD2D, 32'd31);

        // Asynchronous reset between edges with a write pending.
        bus.RFWEW = 1'b1; bus.rtdW = 5'd3; bus.MtoRFSelW = 1'b0; bus.ALUOutW = 32'h77;
        #1;
        RST = 1'b1;
        #1;
        check("async_rst_r3", bus.RD1D, 32'h0);
        check("async_rst_r31", bus.RD2D, 32'h0);
        @(posedge CLK);
        #1;
        check("rst_edge_r3", bus.RD1D, 32'h0);
        bus.RFWEW = 1'b0;
        RST = 1'b0;
        rd(5'd3, 5'd17);
        check("post_rst_r3", bus.RD1D, 32'h0);
        check("post_rst_r17", bus.RD2D, 32'h0);

        // First write after reset lands on the first qualifying edge.
        wr(5'd4, 1'b1, 32'h0, 32'h0000_0044);
        rd(5'd4, 5'd3);
        check("first_write_r4", bus.RD1D, 32'h0000_0044);
        check("first_write_r3", bus.RD2D, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the register and result data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the register address width (2^ADDR_W registers).
REQ-003 The block SHALL have port CLK, input, 1, the single clock; all writes are on its rising edge.
REQ-004 The block SHALL have port RST, input, 1, the reset; it is asynchronous and active-high.
REQ-005 The block SHALL have port RFWEW, input, 1, the writeback register-file write enable from the MEM/WB register.
REQ-006 The block SHALL have port MtoRFSelW, input, 1, the result select: 1 selects memory data, 0 selects ALU result.
REQ-007 The block SHALL have port DMOutW, input, DATA_W, the data-memory read value from the MEM/WB register.
REQ-008 The block SHALL have port ALUOutW, input, DATA_W, the ALU result from the MEM/WB register.
REQ-009 The block SHALL have port rtdW, input, ADDR_W, the destination register address.
REQ-010 The block SHALL have ports rsD and rtD, input, ADDR_W each, the decode-stage read addresses.
REQ-011 The block SHALL have ports RD1D and RD2D, output, DATA_W each, the read data for rsD and rtD.
REQ-012 The block SHALL have port ResultW, output, DATA_W, the selected writeback value.

Function
REQ-013 ResultW SHALL be combinational: DMOutW when MtoRFSelW=1, else ALUOutW.
REQ-014 On each rising CLK edge with RST=0, RFWEW=1 and rtdW!=0, register[rtdW] SHALL take ResultW.
REQ-015 When RFWEW=0, storage SHALL be unchanged regardless of MtoRFSelW, DMOutW, ALUOutW or rtdW, including X values.
REQ-016 Register 0 SHALL never be written, and any read of address 0 SHALL return 0.
REQ-017 Reads SHALL be combinational (zero latency); RD1D/RD2D follow rsD/rtD within the same cycle.
REQ-018 Both read ports SHALL be independent; rsD=rtD SHALL return identical values on both ports.
REQ-019 A write becomes visible on the read ports at the latest in the cycle after its write edge.
REQ-020 Same-cycle read-during-write to the same nonzero address SHALL behave as specified in REQ-024/REQ-025.

Reset
REQ-021 While RST=1, all registers SHALL be 0 asynchronously, without waiting for a CLK edge.
REQ-022 While RST=1, RD1D and RD2D SHALL read 0, and writes SHALL be ignored, including a write enable coincident with the RST assertion edge.
REQ-023 After RST deasserts, the first write SHALL occur on the first rising CLK edge satisfying REQ-014.

Configuration
REQ-024 With macro WB_RF_BYPASS_EN defined: if RFWEW=1, rtdW!=0 and rtdW equals a read address, that port SHALL return ResultW in the same cycle (internal write-through forwarding).
REQ-025 Without WB_RF_BYPASS_EN: read ports SHALL return the stored value only, and the new value SHALL appear the cycle after the write edge; hazard handling is then the hazard unit's job.

Structure
REQ-026 DATA_W/ADDR_W defaults and the constant REG_ZERO (address 0) SHALL live in the shared pipeline package used by the stage registers.
REQ-027 Storage SHALL be one sub-module, rf_core (2R1W array with async clear and zero-register rule); the result mux and bypass logic SHALL sit in wb_regfile.

Verification
REQ-028 The bench SHALL check write-select: RFWEW=1, MtoRFSelW=0, ALUOutW=0x0000_1234, rtdW=5, one edge, then rsD=5 -> RD1D=0x0000_1234; repeat with MtoRFSelW=1, DMOutW=0xDEAD_BEEF -> RD1D=0xDEAD_BEEF.
REQ-029 The bench SHALL check register zero: write 0xFFFF_FFFF to rtdW=0, then rsD=0, rtD=0 -> RD1D=RD2D=0.
REQ-030 The bench SHALL check that a disabled write leaves storage unchanged: RFWEW=0, rtdW=7, ALUOutW=0x55, after reg7=0x11 -> RD2D (rtD=7) stays 0x11.
REQ-031 The bench SHALL check bypass: RFWEW=1, rtdW=9, ALUOutW=0xA5A5_A5A5, rsD=rtD=9 in the same cycle -> both ports 0xA5A5_A5A5 before the edge with WB_RF_BYPASS_EN, old value without it.
REQ-032 The bench SHALL check asynchronous mid-operation reset: fill regs 1..31 with their index, assert RST between edges -> all reads 0 immediately; the write pending at the next edge is dropped; after deassert, reg3 reads 0.
